mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and unified-memory signals of mem_arbiter.
// The arbiter connects through the slave modport; the CPU/memory side uses master.
interface mem_arbiter_if;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_data_out;
    logic        if_ready_out;

    logic        dm_req_in;
    logic        dm_wr_in;
    logic [31:0] dm_addr_in;
    logic [31:0] dm_wdata_in;
    logic [31:0] dm_rdata_out;
    logic        dm_ready_out;

    logic        mem_req_out;
    logic        mem_wr_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;

    logic        stall_out;

    modport slave (
        input  if_req_in, if_addr_in,
        output if_data_out, if_ready_out,
        input  dm_req_in, dm_wr_in, dm_addr_in, dm_wdata_in,
        output dm_rdata_out, dm_ready_out,
        output mem_req_out, mem_wr_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in, mem_ack_in,
        output stall_out
    );

    modport master (
        output if_req_in, if_addr_in,
        input  if_data_out, if_ready_out,
        output dm_req_in, dm_wr_in, dm_addr_in, dm_wdata_in,
        input  dm_rdata_out, dm_ready_out,
        input  mem_req_out, mem_wr_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in, mem_ack_in,
        input  stall_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a unified single-port memory, data-first with a fetch starvation limit.
// Define MEM_ARB_TIMEOUT_EN to add the BUSY watchdog and the sticky err_out port.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic         clk,
    input  logic         reset_in,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic         err_out,
`endif
    mem_arbiter_if.slave arb_if
);

    localparam int DATA_W   = 32;
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                gnt_dm_q, gnt_dm_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                busy;
    logic                starved;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                WD_W         = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
`endif

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
        return (v == STREAK_W'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    // A store completes with zero on the read-data port.
    function automatic logic [DATA_W-1:0] load_data(input logic is_store,
                                                    input logic [DATA_W-1:0] d);
        return is_store ? '0 : d;
    endfunction

    assign busy    = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    assign starved = arb_if.if_req_in && (streak_q == STREAK_W'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        gnt_dm_d   = gnt_dm_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wdog_d     = busy ? wdog_q : '0;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_if.dm_req_in && !starved) begin
                    state_d  = DM_BUSY;
                    gnt_dm_d = 1'b1;
                    wr_d     = arb_if.dm_wr_in;
                    addr_d   = arb_if.dm_addr_in;
                    wdata_d  = arb_if.dm_wdata_in;
                    streak_d = arb_if.if_req_in ? sat_inc(streak_q) : '0;
                end else if (arb_if.if_req_in) begin
                    state_d  = IF_BUSY;
                    gnt_dm_d = 1'b0;
                    wr_d     = 1'b0;
                    addr_d   = arb_if.if_addr_in;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (arb_if.mem_ack_in) begin
                    state_d = DONE;
                    if (gnt_dm_q) begin
                        dm_rdata_d = load_data(wr_q, arb_if.mem_rdata_in);
                    end else begin
                        if_data_d = arb_if.mem_rdata_in;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (gnt_dm_q) begin
                        dm_rdata_d = load_data(wr_q, TIMEOUT_DATA);
                    end else begin
                        if_data_d = TIMEOUT_DATA;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset clears data registers too so every output reads zero while reset is held.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            gnt_dm_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            gnt_dm_q   <= gnt_dm_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    assign arb_if.mem_req_out   = busy;
    assign arb_if.mem_wr_out    = busy & wr_q;
    assign arb_if.mem_addr_out  = busy ? addr_q : '0;
    assign arb_if.mem_wdata_out = busy ? wdata_q : '0;

    assign arb_if.if_ready_out  = (state_q == DONE) & ~gnt_dm_q;
    assign arb_if.dm_ready_out  = (state_q == DONE) & gnt_dm_q;
    assign arb_if.if_data_out   = if_data_q;
    assign arb_if.dm_rdata_out  = dm_rdata_q;

    assign arb_if.stall_out = ~reset_in &
                              ((arb_if.if_req_in & ~arb_if.if_ready_out) |
                               (arb_if.dm_req_in & ~arb_if.dm_ready_out));

`ifdef MEM_ARB_TIMEOUT_EN
    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for latency, grant order, reset and ack handling.
module tb_mem_arbiter;

    localparam int LIM = 4;
    localparam int TMO = 16;
    localparam logic [31:0] EXP23 [7] = '{32'h300, 32'h304, 32'h308, 32'h30C,
                                          32'h200, 32'h310, 32'h314};

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic reset_in = 1'b0;
    mem_arbiter_if bus();
`ifdef MEM_ARB_TIMEOUT_EN
    logic err_out;
`endif

    mem_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset_in (reset_in),
`ifdef MEM_ARB_TIMEOUT_EN
        .err_out  (err_out),
`endif
        .arb_if   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Stimulus state: requests queued by the test, consumed by the driver.
    logic [31:0] if_q[$];
    xfer_t       dm_q[$];
    xfer_t       grant_log[$];
    int          if_idx = 0, dm_idx = 0;
    int          flush_n = 0, flush_used = 0;
    int          force_n = 0, force_used = 0;
    int          ack_after = 1;
    int          bcnt = 0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic        if_seen = 1'b0, dm_seen = 1'b0;

    initial begin
        bus.if_req_in = 0; bus.if_addr_in = 0;
        bus.dm_req_in = 0; bus.dm_wr_in = 0; bus.dm_addr_in = 0; bus.dm_wdata_in = 0;
        bus.mem_ack_in = 0; bus.mem_rdata_in = 0;
    end

    // Requesters and memory responder, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (flush_n != flush_used) begin
            flush_used = flush_n;
            if_idx = if_q.size();
            dm_idx = dm_q.size();
        end else begin
            if (if_seen && if_idx < if_q.size()) if_idx++;
            if (dm_seen && dm_idx < dm_q.size()) dm_idx++;
        end
        bus.if_req_in  = (if_idx < if_q.size());
        bus.if_addr_in = bus.if_req_in ? if_q[if_idx] : 32'h0;
        bus.dm_req_in  = (dm_idx < dm_q.size());
        bus.dm_wr_in    = bus.dm_req_in ? dm_q[dm_idx].wr : 1'b0;
        bus.dm_addr_in  = bus.dm_req_in ? dm_q[dm_idx].addr : 32'h0;
        bus.dm_wdata_in = bus.dm_req_in ? dm_q[dm_idx].wdata : 32'h0;

        if (bus.mem_req_out) bcnt++; else bcnt = 0;
        if (bus.mem_req_out && bcnt == 1)
            grant_log.push_back('{wr: bus.mem_wr_out, addr: bus.mem_addr_out, wdata: bus.mem_wdata_out});
        bus.mem_ack_in = (force_n != force_used) ||
                         (ack_after != 0 && bus.mem_req_out && bcnt == ack_after);
        force_used = force_n;
        bus.mem_rdata_in = ovr_en ? ovr_val : (bus.mem_addr_out ^ 32'h5A5A_0000);
    end

    // Reference model: one transaction in flight, tracked as free / on memory / completing.
    int          ph = 0;
    bit          m_dm = 1'b0;
    xfer_t       m_cur = '0;
    int          m_streak = 0;
    int          m_bsy = 0;
    logic [31:0] m_if_data = '0, m_dm_data = '0;
    bit          m_err = 1'b0;

    function automatic void m_complete(input logic [31:0] v);
        ph = 2;
        if (m_dm) m_dm_data = m_cur.wr ? 32'h0 : v;
        else      m_if_data = v;
    endfunction

    always @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            ph = 0; m_dm = 0; m_cur = '0; m_streak = 0; m_bsy = 0;
            m_if_data = '0; m_dm_data = '0; m_err = 0;
        end else if (ph == 0) begin
            if (bus.dm_req_in && !(bus.if_req_in && m_streak == LIM)) begin
                m_dm = 1; ph = 1; m_bsy = 0;
                m_cur = '{wr: bus.dm_wr_in, addr: bus.dm_addr_in, wdata: bus.dm_wdata_in};
                m_streak = bus.if_req_in ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
            end else if (bus.if_req_in) begin
                m_dm = 0; ph = 1; m_bsy = 0;
                m_cur = '{wr: 1'b0, addr: bus.if_addr_in, wdata: 32'h0};
                m_streak = 0;
            end
        end else if (ph == 1) begin
            m_bsy++;
            if (bus.mem_ack_in) m_complete(bus.mem_rdata_in);
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_bsy == TMO) begin
                m_complete(32'hDEAD_BEEF);
                m_err = 1;
            end
`endif
        end else begin
            ph = 0;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic on_mem, e_ifr, e_dmr;
        if_seen = bus.if_ready_out;
        dm_seen = bus.dm_ready_out;
        on_mem = (ph == 1);
        e_ifr  = (ph == 2) && !m_dm;
        e_dmr  = (ph == 2) && m_dm;
        chk("mem_req",   32'(bus.mem_req_out),  32'(on_mem));
        chk("mem_wr",    32'(bus.mem_wr_out),   32'(on_mem && m_cur.wr));
        chk("mem_addr",  bus.mem_addr_out,      on_mem ? m_cur.addr : 32'h0);
        chk("mem_wdata", bus.mem_wdata_out,     on_mem ? m_cur.wdata : 32'h0);
        chk("if_ready",  32'(bus.if_ready_out), 32'(e_ifr));
        chk("dm_ready",  32'(bus.dm_ready_out), 32'(e_dmr));
        chk("if_data",   bus.if_data_out,       m_if_data);
        chk("dm_rdata",  bus.dm_rdata_out,      m_dm_data);
        chk("stall",     32'(bus.stall_out),
            32'(!reset_in && ((bus.if_req_in && !e_ifr) || (bus.dm_req_in && !e_dmr))));
`ifdef MEM_ARB_TIMEOUT_EN
        chk("err",       32'(err_out),          32'(m_err));
`endif
    end

    task automatic wait_rdy(input bit dm, input int budget, output int n);
        n = 0;
        repeat (budget) begin
            @(negedge clk);
            n++;
            if (dm ? bus.dm_ready_out : bus.if_ready_out) return;
        end
        n_chk++; n_err++;
        $display("FAIL wait_ready(dm=%0d): got no pulse in %0d cycles, expected one", dm, budget);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset_in = 1'b1;
        flush_n++;
        @(negedge clk);
        @(posedge clk); #3 reset_in = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        #2 reset_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_out), 32'h0);
        chk("rst_if_rdy",  32'(bus.if_ready_out), 32'h0);
        chk("rst_stall",   32'(bus.stall_out), 32'h0);
        @(posedge clk); #3 reset_in = 1'b0;

        // Fetch only, ack in the second BUSY cycle.
        @(negedge clk);
        base = grant_log.size();
        ack_after = 2; ovr_en = 1; ovr_val = 32'h8C08_0004;
        if_q.push_back(32'h40);
        wait_rdy(0, 20, n);
        chk("t21_latency", 32'(n), 32'd4);
        chk("t21_if_data", bus.if_data_out, 32'h8C08_0004);
        chk("t21_grant_wr", 32'(grant_log[base].wr), 32'h0);
        @(negedge clk);
        chk("t21_pulse_len", 32'(bus.if_ready_out), 32'h0);
        chk("t21_data_hold", bus.if_data_out, 32'h8C08_0004);
        ovr_en = 0;

        // Minimum latency: ack in the first BUSY cycle.
        ack_after = 1;
        if_q.push_back(32'h44);
        wait_rdy(0, 20, n);
        chk("t11_latency", 32'(n), 32'd3);
        chk("t11_if_data", bus.if_data_out, 32'h5A5A_0044);
        @(negedge clk);

        // Simultaneous store and fetch: store goes first.
        base = grant_log.size();
        dm_q.push_back('{wr: 1'b1, addr: 32'h100, wdata: 32'h1234});
        if_q.push_back(32'h40);
        wait_rdy(1, 20, n);
        chk("t22_dm_latency", 32'(n), 32'd3);
        chk("t22_stall_dm",   32'(bus.stall_out), 32'h1);
        chk("t22_dm_rdata",   bus.dm_rdata_out, 32'h0);
        wait_rdy(0, 20, n);
        chk("t22_if_after",   32'(n), 32'd3);
        chk("t22_stall_end",  32'(bus.stall_out), 32'h0);
        chk("t22_g0_addr",    grant_log[base].addr, 32'h100);
        chk("t22_g0_wr",      32'(grant_log[base].wr), 32'h1);
        chk("t22_g0_wdata",   grant_log[base].wdata, 32'h1234);
        chk("t22_g1_addr",    grant_log[base+1].addr, 32'h40);
        @(negedge clk);

        // Continuous data traffic with a waiting fetch: 4 data, 1 fetch, then data.
        base = grant_log.size();
        for (int i = 0; i < 6; i++)
            dm_q.push_back('{wr: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0});
        if_q.push_back(32'h200);
        n = 0;
        while ((if_idx < if_q.size() || dm_idx < dm_q.size()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t23_grants", 32'(grant_log.size() - base), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t23_grant%0d", i), grant_log[base+i].addr, EXP23[i]);
        repeat (2) @(negedge clk);

        // Reset during DM_BUSY, then a late ack.
        ack_after = 0;
        dm_q.push_back('{wr: 1'b0, addr: 32'h500, wdata: 32'h0});
        n = 0;
        while (!bus.mem_req_out && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t24_busy", 32'(bus.mem_req_out), 32'h1);
        @(posedge clk); #3 reset_in = 1'b1;
        flush_n++;
        @(negedge clk);
        chk("t24_rst_req",   32'(bus.mem_req_out), 32'h0);
        chk("t24_rst_addr",  bus.mem_addr_out, 32'h0);
        chk("t24_rst_stall", 32'(bus.stall_out), 32'h0);
        chk("t24_rst_data",  bus.if_data_out, 32'h0);
        @(posedge clk); #3 reset_in = 1'b0;
        @(negedge clk);
        force_n++;
        repeat (4) begin
            @(negedge clk);
            chk("t24_no_rdy", 32'(bus.dm_ready_out | bus.if_ready_out), 32'h0);
            chk("t24_idle",   32'(bus.mem_req_out), 32'h0);
        end
        ack_after = 1;

        // Ack while idle with nothing pending.
        force_n++;
        repeat (3) begin
            @(negedge clk);
            chk("t26_no_rdy", 32'(bus.dm_ready_out | bus.if_ready_out), 32'h0);
            chk("t26_idle",   32'(bus.mem_req_out), 32'h0);
        end
        if_q.push_back(32'h80);
        wait_rdy(0, 20, n);
        chk("t26_after_lat",  32'(n), 32'd3);
        chk("t26_after_data", bus.if_data_out, 32'h5A5A_0080);
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: no ack ever.
        ack_after = 0;
        if_q.push_back(32'h60);
        wait_rdy(0, 60, n);
        chk("t25_latency", 32'(n), 32'd18);
        chk("t25_data",    bus.if_data_out, 32'hDEAD_BEEF);
        chk("t25_err",     32'(err_out), 32'h1);
        repeat (3) @(negedge clk);
        chk("t25_err_sticky", 32'(err_out), 32'h1);
        do_reset();
        @(negedge clk);
        chk("t25_err_clr", 32'(err_out), 32'h0);
        ack_after = 1;
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, expected to finish", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
